// File: rtl/md_ctrl.sv
// md_ctrl: pipeline-side issue/stall/readback controller for the MULT_DIV unit.
// Watches the unit's Busy handshake and flags a unit that never starts or never finishes.
module md_ctrl #(
  parameter int WDOG_MAX = 16
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        req_valid,
  input  logic [2:0]  req_kind,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        stall,
  output logic [31:0] rd_val,
  output logic        rd_valid,
  output logic        err,
  output logic [31:0] D1,
  output logic [31:0] D2,
  output logic [1:0]  Op,
  output logic        Start,
  output logic        We,
  output logic        HiLo,
  input  logic        Busy,
  input  logic [31:0] HI,
  input  logic [31:0] LO
);

  localparam int CW = $clog2(WDOG_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    ARM,
    RUN
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0] cnt, cnt_nx;
  logic err_nx;
  logic start_nx, we_nx, rdv_nx;
  logic ld_ops, ld_mt, ld_rd;
  logic open, accept;
  logic is_arith, is_mf, is_mt;

  // RUN with Busy low is the exit cycle; it issues like IDLE
  assign open = (state == IDLE) |
                ((state == RUN) & ~Busy);

  assign stall  = req_valid & (~open | Busy);
  assign accept = req_valid & ~stall;

  assign is_arith = ~req_kind[2];
  assign is_mf    = req_kind[2] & ~req_kind[1];
  assign is_mt    = req_kind[2] & req_kind[1];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    err_nx   = err;
    start_nx = 1'b0;
    we_nx    = 1'b0;
    rdv_nx   = 1'b0;
    ld_ops   = 1'b0;
    ld_mt    = 1'b0;
    ld_rd    = 1'b0;

    unique case (state)
      IDLE: ;
      WR: state_nx = IDLE;
      // first ARM cycle carries Start; Busy is judged one cycle later
      ARM: begin
        if (!Start) begin
          if (Busy) begin
            state_nx = RUN;
            cnt_nx   = CW'(1);
          end else begin
            err_nx   = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      RUN: begin
        if (!Busy) begin
          state_nx = IDLE;
        end else if (cnt == CW'(WDOG_MAX)) begin
          err_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (accept) begin
      unique case (1'b1)
        is_arith: begin
          ld_ops   = 1'b1;
          start_nx = 1'b1;
          state_nx = ARM;
        end
        is_mt: begin
          ld_mt    = 1'b1;
          we_nx    = 1'b1;
          state_nx = WR;
        end
        is_mf: begin
          ld_rd    = 1'b1;
          rdv_nx   = 1'b1;
          state_nx = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      cnt      <= '0;
      err      <= 1'b0;
      Start    <= 1'b0;
      We       <= 1'b0;
      rd_valid <= 1'b0;
      rd_val   <= '0;
      D1       <= '0;
      D2       <= '0;
      Op       <= '0;
      HiLo     <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      err      <= err_nx;
      Start    <= start_nx;
      We       <= we_nx;
      rd_valid <= rdv_nx;
      if (ld_ops | ld_mt) D1 <= rs_val;
      if (ld_ops) begin
        D2 <= rt_val;
        Op <= req_kind[1:0];
      end
      if (ld_mt) HiLo <= (req_kind == 3'd6);
      if (ld_rd) rd_val <= req_kind[0] ? LO : HI;
    end
  end

endmodule
